lab_pattern_scheduler: RTL and testbench
========================================

// Module: lab_pattern_scheduler
// PURPOSE
//  Sequences the graphics pattern datapath from recognized musical notes.
//  - Input: the note recognizer's note_vld/note_idx stream, plus key/sw inputs.
//  - Filters notes through a confirmation counter and a minimum hold time.
//  - Commits pattern changes only at frame start, so a frame never switches pattern mid-scan.
//  - Owns the animation tick and the cursor counters cnt1/cnt2 consumed by the pattern logic.
// PARAMETERS
//  screen_width  640  horizontal pixels; cnt1 wraps at screen_width-1
//  screen_height 480  vertical pixels; cnt2 re-centres at 0 or screen_height-1
//  w_tick        20   tick period = 2**w_tick clk cycles
//  confirm_cnt   3    consecutive identical note_vld events needed to confirm a note
//  hold_ticks    16   minimum ticks a committed pattern is held
//  auto_ticks    64   idle ticks before auto-advance (only with LAB_PATTERN_AUTO_CYCLE_EN)
//  w_x/w_y       $clog2(screen_width/height)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous, active-high reset
//  note_vld    in   1        one-cycle strobe: note_idx valid
//  note_idx    in   4        note 0..11; values 12..15 ignored
//  in_up       in   1        move cursor down (+1 per tick)
//  in_dn       in   1        move cursor up (-1 per tick)
//  x           in   w_x      current scan x
//  y           in   w_y      current scan y
//  pattern     out  2        committed pattern_t
//  pattern_chg out  1        one-cycle strobe on commit
//  anim_tick   out  1        one-cycle strobe every 2**w_tick cycles
//  cnt1        out  w_x      horizontal cursor
//  cnt2        out  w_y      vertical cursor
// BEHAVIOUR
//  Reset: pattern=PAT_QUADRANT, pattern_chg=0, anim_tick=0, cnt1=0, cnt2=screen_height/2, FSM=S_IDLE, all timers 0.
//  Tick: free-running w_tick-bit counter; anim_tick=1 in the cycle the counter is 0 (registered, never during rst).
//  Mapping: note_idx mod 3 -> 0:GRADIENT, 1:HYPERBOLA, 2:DIAGONAL.
//  Confirm: cand_note/cand_cnt are updated on every valid note_vld, whatever the FSM state.
//   - Same idx as cand_note: cand_cnt saturates at confirm_cnt.
//   - Different idx: cand_note<=idx, cand_cnt<=1.
//   - Invalid idx (>=12): no effect.
//  FSM:
//   - S_IDLE: confirmed note (cand_cnt reaches confirm_cnt this cycle) -> S_PEND with pend=map(note).
//   - S_PEND: waits for frame_start (x==0 && y==0).
//     - On frame_start: pattern<=pend, pattern_chg=1 next cycle, cnt1<=0, hold timer<=hold_ticks -> S_HOLD.
//     - A newer confirmation while in S_PEND overwrites pend.
//   - S_HOLD: timer decrements on anim_tick; at 0 -> S_IDLE. Confirmations during S_HOLD are discarded.
//   - If a confirmed pattern equals the current pattern: no commit, no pattern_chg, FSM stays in S_IDLE.
//  Cursor (on anim_tick only):
//   - cnt1: +1, wrapping screen_width-1 -> 0.
//   - cnt2 at 0 or screen_height-1: set to screen_height/2.
//   - Otherwise cnt2 += in_up - in_dn; both pressed gives no move.
//  Simultaneous: a commit and an anim_tick in the same cycle -> commit wins for cnt1 (cnt1=0); cnt2 still steps.
//  Reset mid-operation returns everything to reset values in the next cycle; a pending pattern is lost.
// CONFIGURATION
//  LAB_PATTERN_AUTO_CYCLE_EN defined:
//   - In S_IDLE, an idle counter counts anim_ticks and is cleared by any valid note_vld.
//   - When it reaches auto_ticks: pend=(pattern+1) mod 4 -> S_PEND; the counter clears.
//  Undefined: no idle counter; pattern changes only via confirmed notes.
// STRUCTURE
//  Package lab_pattern_pkg:
//   - typedef enum logic [1:0] pattern_t {PAT_GRADIENT, PAT_HYPERBOLA, PAT_DIAGONAL, PAT_QUADRANT}
//   - typedef enum sched_state_t {S_IDLE, S_PEND, S_HOLD}
//   - function note_to_pattern(logic [3:0])
//  Sub-module lab_tick_gen (w_tick): produces the anim_tick strobe.
//  Everything else lives in this module.
// TESTING (sim params: w_tick=4, confirm_cnt=3, hold_ticks=2, auto_ticks=4, 16x8 screen)
//  1. After reset -> pattern=QUADRANT, cnt1=0, cnt2=4, anim_tick every 16 cycles.
//  2. Notes 4,4,4, frame_start 10 cycles later -> pattern=HYPERBOLA exactly after frame_start; one pattern_chg pulse; cnt1=0.
//  3. Notes 4,4,7,7 -> no commit (cand_cnt=2); a further 7 -> commit, since 7 mod 3 = 1 (HYPERBOLA).
//  4. Commit GRADIENT, then notes 2,2,2 within 2 ticks -> ignored; notes 2,2,2 after the hold expires -> DIAGONAL.
//  5. in_up held -> cnt2 4,5,6,7 then 4 (re-centre); cnt1 wraps 15->0; in_up+in_dn together -> cnt2 unchanged.
//  6. With LAB_PATTERN_AUTO_CYCLE_EN: no notes for 4 ticks -> QUADRANT->GRADIENT at the next frame_start; without the macro, pattern stays.

Source files
------------

// File: rtl/lab_pattern_scheduler_pkg.sv
// Shared types for the pattern scheduler: pattern and scheduler-state enums
// plus the note-to-pattern mapping.
package lab_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_GRADIENT,
    PAT_HYPERBOLA,
    PAT_DIAGONAL,
    PAT_QUADRANT
  } pattern_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_HOLD
  } sched_state_t;

  localparam logic [3:0] NOTE_LIMIT = 4'd12;

  function automatic pattern_t note_to_pattern(logic [3:0] idx);
    case (idx % 4'd3)
      4'd0:    note_to_pattern = PAT_GRADIENT;
      4'd1:    note_to_pattern = PAT_HYPERBOLA;
      default: note_to_pattern = PAT_DIAGONAL;
    endcase
  endfunction

endpackage

// File: rtl/lab_pattern_scheduler_if.sv
// Note-recognizer stream into the pattern scheduler: one-cycle valid strobe
// with the recognized note index.
interface lab_pattern_scheduler_if;
  logic       note_vld;
  logic [3:0] note_idx;

  modport master (output note_vld, output note_idx);
  modport slave  (input  note_vld, input  note_idx);
endinterface

// File: rtl/lab_pattern_scheduler_tick_gen.sv
// Animation tick generator: free-running w_tick-bit counter, registered strobe
// high for one cycle each time the counter sits at zero.
module lab_tick_gen #(
  parameter int unsigned w_tick = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [w_tick-1:0] ONE = w_tick'(1);

  logic [w_tick-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + ONE;
    tick_d = (cnt_q == '1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/lab_pattern_scheduler.sv
// Pattern scheduler: confirms notes, commits pattern changes at frame start,
// owns the animation tick and cursors. LAB_PATTERN_AUTO_CYCLE_EN adds idle auto-advance.
//
// state  | meaning
// S_IDLE | no change pending; watching for a confirmed note
// S_PEND | new pattern chosen, waiting for x==0 && y==0
// S_HOLD | pattern just committed; held for hold_ticks anim ticks
module lab_pattern_scheduler
  import lab_pattern_pkg::*;
#(
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_tick        = 20,
  parameter int unsigned confirm_cnt   = 3,
  parameter int unsigned hold_ticks    = 16,
  parameter int unsigned auto_ticks    = 64,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  lab_pattern_scheduler_if.slave  note_if,
  input  logic                    in_up_i,
  input  logic                    in_dn_i,
  input  logic [w_x-1:0]          x_i,
  input  logic [w_y-1:0]          y_i,
  output pattern_t                pattern_o,
  output logic                    pattern_chg_o,
  output logic                    anim_tick_o,
  output logic [w_x-1:0]          cnt1_o,
  output logic [w_y-1:0]          cnt2_o
);

  localparam int unsigned w_c = $clog2(confirm_cnt + 1);
  localparam int unsigned w_h = $clog2(hold_ticks + 1);

  localparam logic [w_c-1:0] CONF_C = w_c'(confirm_cnt);
  localparam logic [w_c-1:0] C_ONE  = w_c'(1);
  localparam logic [w_h-1:0] HOLD_C = w_h'(hold_ticks);
  localparam logic [w_h-1:0] H_ONE  = w_h'(1);
  localparam logic [w_x-1:0] X_LAST = w_x'(screen_width - 1);
  localparam logic [w_x-1:0] X_ONE  = w_x'(1);
  localparam logic [w_y-1:0] Y_LAST = w_y'(screen_height - 1);
  localparam logic [w_y-1:0] Y_MID  = w_y'(screen_height / 2);
  localparam logic [w_y-1:0] Y_ONE  = w_y'(1);

  sched_state_t   state_q, state_d;
  pattern_t       pattern_q, pattern_d;
  pattern_t       pend_q, pend_d;
  logic           chg_q, chg_d;
  logic [w_h-1:0] hold_q, hold_d;
  logic [3:0]     cand_note_q, cand_note_d;
  logic [w_c-1:0] cand_cnt_q, cand_cnt_d;
  logic [w_x-1:0] cnt1_q, cnt1_d;
  logic [w_y-1:0] cnt2_q, cnt2_d;

  logic     anim_tick;
  logic     note_ok;
  logic     confirm;
  logic     frame_start;
  logic     commit;
  logic     auto_fire;
  pattern_t conf_pat;

  lab_tick_gen #(.w_tick(w_tick)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (anim_tick)
  );

  assign note_ok     = note_if.note_vld && (note_if.note_idx < NOTE_LIMIT);
  assign conf_pat    = note_to_pattern(note_if.note_idx);
  assign frame_start = (x_i == '0) && (y_i == '0);

  // Candidate tracking runs regardless of FSM state; a saturated run keeps confirming.
  always_comb begin
    cand_note_d = cand_note_q;
    cand_cnt_d  = cand_cnt_q;
    if (note_ok) begin
      if (note_if.note_idx == cand_note_q) begin
        if (cand_cnt_q != CONF_C) cand_cnt_d = cand_cnt_q + C_ONE;
      end else begin
        cand_note_d = note_if.note_idx;
        cand_cnt_d  = C_ONE;
      end
    end
  end

  assign confirm = note_ok && (cand_cnt_d == CONF_C);

`ifdef LAB_PATTERN_AUTO_CYCLE_EN
  localparam int unsigned w_i = $clog2(auto_ticks + 1);
  localparam logic [w_i-1:0] I_LAST = w_i'(auto_ticks - 1);
  localparam logic [w_i-1:0] I_ONE  = w_i'(1);

  logic [w_i-1:0] idle_q, idle_d;

  always_comb begin
    idle_d    = idle_q;
    auto_fire = 1'b0;
    if (state_q != S_IDLE || note_ok) begin
      idle_d = '0;
    end else if (anim_tick) begin
      if (idle_q == I_LAST) begin
        idle_d    = '0;
        auto_fire = 1'b1;
      end else begin
        idle_d = idle_q + I_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    chg_d     = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (confirm && conf_pat != pattern_q) begin
          pend_d  = conf_pat;
          state_d = S_PEND;
        end else if (auto_fire) begin
          pend_d  = pattern_t'(pattern_q + 2'd1);
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        // A later confirmation replaces the pending choice; one matching the
        // live pattern cancels the change altogether.
        if (confirm) pend_d = conf_pat;
        if (confirm && conf_pat == pattern_q) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          pattern_d = pend_d;
          chg_d     = 1'b1;
          hold_d    = HOLD_C;
          commit    = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else if (anim_tick) begin
          hold_d = hold_q - H_ONE;
          if (hold_q == H_ONE) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (anim_tick) begin
      cnt1_d = (cnt1_q == X_LAST) ? '0 : cnt1_q + X_ONE;
      if (cnt2_q == '0 || cnt2_q == Y_LAST) cnt2_d = Y_MID;
      else if (in_up_i && !in_dn_i)         cnt2_d = cnt2_q + Y_ONE;
      else if (in_dn_i && !in_up_i)         cnt2_d = cnt2_q - Y_ONE;
    end
    if (commit) cnt1_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pattern_q   <= PAT_QUADRANT;
      pend_q      <= PAT_QUADRANT;
      chg_q       <= 1'b0;
      hold_q      <= '0;
      cand_note_q <= '0;
      cand_cnt_q  <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= Y_MID;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      pend_q      <= pend_d;
      chg_q       <= chg_d;
      hold_q      <= hold_d;
      cand_note_q <= cand_note_d;
      cand_cnt_q  <= cand_cnt_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
    end
  end

  assign pattern_o     = pattern_q;
  assign pattern_chg_o = chg_q;
  assign anim_tick_o   = anim_tick;
  assign cnt1_o        = cnt1_q;
  assign cnt2_o        = cnt2_q;

endmodule

// File: tb/tb_lab_pattern_scheduler.sv
// Bench for lab_pattern_scheduler: run-length/event model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lab_pattern_scheduler;
  import lab_pattern_pkg::*;

  localparam int SW = 16, SH = 8, WT = 4, CONF = 3, HOLD = 2, AUTO = 4;
  localparam int WX = 4, WY = 3;
  localparam int TPER = 1 << WT;
`ifdef LAB_PATTERN_AUTO_CYCLE_EN
  localparam int EXP_AUTO_PAT = 0;
`else
  localparam int EXP_AUTO_PAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_up = 1'b0, in_dn = 1'b0;
  logic [WX-1:0] x = 4'd1;
  logic [WY-1:0] y = 3'd1;
  pattern_t      pattern;
  logic          pattern_chg, anim_tick;
  logic [WX-1:0] cnt1;
  logic [WY-1:0] cnt2;

  lab_pattern_scheduler_if nif ();

  always #5 clk = ~clk;

  lab_pattern_scheduler #(
    .screen_width (SW), .screen_height (SH), .w_tick (WT),
    .confirm_cnt (CONF), .hold_ticks (HOLD), .auto_ticks (AUTO)
  ) dut (
    .clk_i (clk), .rst_i (rst), .note_if (nif),
    .in_up_i (in_up), .in_dn_i (in_dn), .x_i (x), .y_i (y),
    .pattern_o (pattern), .pattern_chg_o (pattern_chg), .anim_tick_o (anim_tick),
    .cnt1_o (cnt1), .cnt2_o (cnt2)
  );

  int errors = 0, checks = 0;
  int chg_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edge counting for the tick, run lengths for confirmation,
  // flags for pending/holding.
  int  m_edges = 0, m_pat = 3, m_cnt1 = 0, m_cnt2 = SH / 2;
  int  m_last_note = 0, m_run = 0, m_pend = 0, m_hold_left = 0, m_idle = 0;
  bit  m_pending = 0, m_holding = 0, m_chg = 0, m_tick = 0, m_live = 0;

  always @(posedge clk) begin : model
    bit tick_now, frame, valid, confirm, commit, was_idle;
    int p;
    if (rst) begin
      m_edges = 0; m_pat = 3; m_cnt1 = 0; m_cnt2 = SH / 2;
      m_last_note = 0; m_run = 0; m_pending = 0; m_holding = 0;
      m_hold_left = 0; m_idle = 0; m_chg = 0; m_tick = 0; m_live = 1;
    end else begin
      tick_now = (m_edges != 0) && (m_edges % TPER == 0);
      m_edges++;
      frame   = (x == 0) && (y == 0);
      valid   = nif.note_vld && (nif.note_idx < 12);
      p       = int'(nif.note_idx) % 3;
      confirm = 0;
      commit  = 0;
      if (valid) begin
        if (int'(nif.note_idx) == m_last_note) m_run++;
        else begin m_last_note = int'(nif.note_idx); m_run = 1; end
        confirm = (m_run >= CONF);
      end
      was_idle = !m_holding && !m_pending;
      if (m_holding) begin
        if (tick_now) begin
          m_hold_left--;
          if (m_hold_left == 0) m_holding = 0;
        end
      end else if (m_pending) begin
        if (confirm) begin
          if (p == m_pat) m_pending = 0;
          else m_pend = p;
        end
        if (m_pending && frame) commit = 1;
      end else begin
        if (confirm && p != m_pat) begin
          m_pending = 1; m_pend = p;
        end
`ifdef LAB_PATTERN_AUTO_CYCLE_EN
        else if (!valid && tick_now) begin
          m_idle++;
          if (m_idle == AUTO) begin
            m_pending = 1; m_pend = (m_pat + 1) % 4; m_idle = 0;
          end
        end
`endif
      end
      if (!was_idle || valid) m_idle = 0;
      if (commit) begin
        m_pat = m_pend; m_pending = 0; m_holding = 1; m_hold_left = HOLD;
      end
      m_chg = commit;
      if (tick_now) begin
        m_cnt1 = (m_cnt1 + 1) % SW;
        if (m_cnt2 == 0 || m_cnt2 == SH - 1) m_cnt2 = SH / 2;
        else m_cnt2 = m_cnt2 + int'(in_up) - int'(in_dn);
      end
      if (commit) m_cnt1 = 0;
      m_tick = (m_edges % TPER == 0);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("pattern",     int'(pattern),     m_pat);
      chk("pattern_chg", int'(pattern_chg), int'(m_chg));
      chk("anim_tick",   int'(anim_tick),   int'(m_tick));
      chk("cnt1",        int'(cnt1),        m_cnt1);
      chk("cnt2",        int'(cnt2),        m_cnt2);
      if (pattern_chg) chg_count++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; nif.note_vld = 1'b0; in_up = 1'b0; in_dn = 1'b0; x = 4'd1; y = 3'd1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic send_note(input int idx);
    nif.note_vld = 1'b1; nif.note_idx = 4'(idx);
    cyc(1);
    nif.note_vld = 1'b0;
    cyc(1);
  endtask

  task automatic frame();
    x = 4'd0; y = 3'd0;
    cyc(1);
    x = 4'd1; y = 3'd1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (anim_tick !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("tick_within_budget", int'(n < 40), 1);
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_cnt2[4];
    exp_cnt2 = '{5, 6, 7, 4};
    nif.note_vld = 1'b0;
    nif.note_idx = 4'd0;

    // 1: reset values and tick period
    do_reset();
    chk("rst_pattern", int'(pattern), 3);
    chk("rst_cnt1", int'(cnt1), 0);
    chk("rst_cnt2", int'(cnt2), 4);
    chk("rst_tick", int'(anim_tick), 0);
    wait_tick(n);
    chk("first_tick_delay", n, 16);
    wait_tick(n);
    chk("tick_period", n, 15);

    // 2: confirmed note committed only at frame start
    do_reset();
    send_note(4); send_note(4); send_note(4);
    cyc(10);
    chk("t2_before_frame", int'(pattern), 3);
    chg_count = 0;
    frame();
    chk("t2_pattern", int'(pattern), 1);
    chk("t2_chg", int'(pattern_chg), 1);
    chk("t2_cnt1", int'(cnt1), 0);
    cyc(5);
    chk("t2_chg_pulses", chg_count, 1);

    // 3: interrupted run, then completion; invalid index ignored
    do_reset();
    send_note(4); send_note(4); send_note(7); send_note(7);
    frame();
    chk("t3_no_commit", int'(pattern), 3);
    chk("t3_no_chg", int'(pattern_chg), 0);
    send_note(7);
    frame();
    chk("t3_commit", int'(pattern), 1);
    do_reset();
    send_note(5); send_note(5); send_note(13);
    frame();
    chk("t3_invalid_no_commit", int'(pattern), 3);
    send_note(5);
    frame();
    chk("t3_invalid_skipped", int'(pattern), 2);

    // 4: hold discards notes; same-pattern confirm does nothing
    do_reset();
    send_note(3); send_note(3); send_note(3);
    frame();
    chk("t4_gradient", int'(pattern), 0);
    send_note(2); send_note(2); send_note(2);
    frame();
    chk("t4_hold_pattern", int'(pattern), 0);
    chk("t4_hold_chg", int'(pattern_chg), 0);
    cyc(50);
    chg_count = 0;
    send_note(9); send_note(9); send_note(9);
    frame();
    cyc(2);
    chk("t4_same_pattern", int'(pattern), 0);
    chk("t4_same_no_chg", chg_count, 0);
    send_note(2); send_note(2); send_note(2);
    frame();
    chk("t4_diagonal", int'(pattern), 2);

    // 5: cursor stepping, re-centre, wrap, both buttons
    do_reset();
    in_up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      chk("t5_cnt2_up", int'(cnt2), exp_cnt2[k]);
    end
    chk("t5_cnt1_4", int'(cnt1), 4);
    in_dn = 1'b1;
    for (int k = 0; k < 11; k++) wait_tick(n);
    chk("t5_cnt1_15", int'(cnt1), 15);
    chk("t5_cnt2_both", int'(cnt2), 4);
    wait_tick(n);
    chk("t5_cnt1_wrap", int'(cnt1), 0);
    in_up = 1'b0; in_dn = 1'b0;

    // 6: idle auto-advance (only with the macro)
    do_reset();
    for (int k = 0; k < 4; k++) wait_tick(n);
    cyc(3);
    frame();
    chk("t6_auto", int'(pattern), EXP_AUTO_PAT);
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
